// File: rtl/tetris_pkg.sv
// Shared board geometry, FSM state encoding and line-clear score constants.
// Holds no ports. Imported by line_clear_engine and line_score_lut.
package tetris_pkg;

    localparam int unsigned BOARD_ROWS = 23;
    localparam int unsigned BOARD_COLS = 10;
    localparam int unsigned BOARD_BITS = BOARD_ROWS * BOARD_COLS;

    localparam int unsigned IDX_W   = 5;
    localparam int unsigned SCORE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_1 = 16'd40;
    localparam logic [SCORE_W-1:0] SCORE_2 = 16'd100;
    localparam logic [SCORE_W-1:0] SCORE_3 = 16'd300;
    localparam logic [SCORE_W-1:0] SCORE_4 = 16'd1200;

endpackage

// File: rtl/line_score_lut.sv
// Combinational score increment for k lines cleared by one lock event.
// Ports:
//   k    in   5  lines cleared by the operation
//   inc  out 16  score increment (k > 4 earns the same as k == 4)
module line_score_lut
    import tetris_pkg::*;
(
    input  logic [IDX_W-1:0]   k,
    output logic [SCORE_W-1:0] inc
);

    always_comb begin
        inc = SCORE_4;
        case (k)
            5'd0:    inc = '0;
            5'd1:    inc = SCORE_1;
            5'd2:    inc = SCORE_2;
            5'd3:    inc = SCORE_3;
            default: inc = SCORE_4;
        endcase
    end

endmodule

// File: rtl/line_clear_engine.sv
// Post-lock line clearing: scans the merged board bottom-to-top, removes every
// full row, collapses the rows above it and republishes the compacted board.
// Optional feature macro: LINE_CLEAR_SCORE_EN (accumulated, saturating score).
// Ports:
//   clk_50         in   1          system clock
//   resetn         in   1          synchronous active-low reset
//   start          in   1          pulse: merged board valid on board_in
//   board_in       in   ROWS*COLS  merged board, row r at [r*COLS +: COLS]
//   board_out      out  ROWS*COLS  compacted board, same mapping
//   busy           out  1          operation in progress
//   done           out  1          one-cycle pulse, results valid
//   lines_cleared  out  5          rows removed by the last operation
//   score          out  16         accumulated score (zero without the macro)
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS = BOARD_ROWS,
    parameter int unsigned COLS = BOARD_COLS
) (
    input  logic                   clk_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [ROWS*COLS-1:0]   board_in,
    output logic [ROWS*COLS-1:0]   board_out,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       lines_cleared,
    output logic [SCORE_W-1:0]     score
);

    localparam int unsigned BITS = ROWS * COLS;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SCAN  = ST_SCAN;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]         state, state_next;
    logic [BITS-1:0]    work, work_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [IDX_W-1:0]   cnt, cnt_next;
    logic [BITS-1:0]    board_next;
    logic [IDX_W-1:0]   lines_next;
    logic               done_next;
    logic               busy_next;
    logic               row_full;

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        work_next  = work;
        idx_next   = idx;
        cnt_next   = cnt;
        board_next = board_out;
        lines_next = lines_cleared;
        done_next  = 1'b0;
        busy_next  = 1'b0;
        row_full   = &work[idx*COLS +: COLS];

        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = board_in;
                    idx_next   = IDX_W'(ROWS - 1);
                    cnt_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_next = SHIFT;
                end else if (idx == '0) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx - 1'b1;
                end
            end
            SHIFT: begin
                // Rows 1..idx move down one; rows below idx keep their value
                for (int unsigned r = 1; r < ROWS; r++) begin
                    if (IDX_W'(r) <= idx) begin
                        work_next[r*COLS +: COLS] = work[(r-1)*COLS +: COLS];
                    end
                end
                work_next[0 +: COLS] = '0;
                cnt_next   = cnt + 1'b1;
                state_next = SCAN;
            end
            DONE: begin
                board_next = work;
                lines_next = cnt;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // busy stays up through the done cycle so it falls together with done
        busy_next = (state_next != IDLE) || (state == DONE);
    end

    // State and output registers
    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            state         <= IDLE;
            work          <= '0;
            idx           <= '0;
            cnt           <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            work          <= work_next;
            idx           <= idx_next;
            cnt           <= cnt_next;
            board_out     <= board_next;
            lines_cleared <= lines_next;
            done          <= done_next;
            busy          <= busy_next;
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W:0]   score_sum;

    line_score_lut u_line_score_lut (
        .k   (cnt),
        .inc (score_inc)
    );

    assign score_sum = {1'b0, score} + {1'b0, score_inc};

    // Saturating accumulate once per completed operation
    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            score <= '0;
        end else if (state == DONE) begin
            score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: doc/line_clear_engine.md
# line_clear_engine

Post-lock line clearing stage. Sits directly downstream of the board recorder: once a falling piece has been merged into the stacked-tile vector, this block scans the board bottom-to-top, removes every full row, collapses the rows above it, and republishes the compacted board. Its output vector is the stacked-tile board consumed by movement control and the display path. It also reports the number of lines removed per lock event.

## Interface
Parameters:
- ROWS, 23, board height; row 0 is the top, row ROWS-1 is the bottom.
- COLS, 10, board width.

Ports:
- clk_50  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request: a newly merged board is on board_in.
- board_in  in  ROWS*COLS  merged board; row r occupies [r*COLS +: COLS].
- board_out  out  ROWS*COLS  compacted board, same bit mapping.
- busy  out  1  high whenever the block is not IDLE.
- done  out  1  one-cycle pulse; board_out and lines_cleared are valid.
- lines_cleared  out  5  number of rows removed by the last operation, 0..ROWS.
- score  out  16  accumulated score (see Configuration).

## Operation
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE: start=1 -> capture board_in into the working register, set row index to ROWS-1, clear the line counter, go to SCAN. start=0 -> stay.
- SCAN: test working row[idx] for all COLS bits set.
  - Full -> SHIFT; idx is unchanged.
  - Not full, idx==0 -> DONE.
  - Not full, idx>0 -> idx-1, stay in SCAN.
- SHIFT: in one cycle, for r=idx..1 row[r] <= row[r-1], and row[0] <= 0. Rows below idx are untouched. Line counter +1. Return to SCAN at the same idx, so the row shifted into idx is rescanned.
- DONE: board_out <= working register, lines_cleared <= counter, done=1, score update, go to IDLE.
- start is ignored while busy=1.
- board_out holds its last value between operations.
- Row index is 5 bits; idx never wraps below 0.
- The line counter cannot overflow: its maximum is ROWS.
- A full row 0 is replaced by zeros. A board with every row full ends all-zero with lines_cleared=ROWS.

## Timing
- Reset values: board_out=0, busy=0, done=0, lines_cleared=0, score=0; FSM to IDLE.
- Reset in the middle of an operation aborts it. The partial result is discarded, and a start in the same cycle as reset is ignored.
- Let N be the edge that samples start in IDLE.
- busy rises at edge N.
- done rises at edge N+ROWS+1+2k, where k is the number of lines cleared: each cleared line adds one SCAN cycle and one SHIFT cycle.
- busy falls and done falls together, one edge later.
- Minimum busy-to-busy restart: a start presented in the cycle in which done is high is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- LINE_CLEAR_SCORE_EN defined: at DONE, score <= score + table[k].
  - Table: 0/40/100/300/1200 for k=0/1/2/3/4; any k>4 uses 1200.
  - The sum saturates at 16'hFFFF.
  - score is cleared only by reset.
- LINE_CLEAR_SCORE_EN undefined: no table and no adder; score is tied to 16'd0. Port list is unchanged.

## Structure
- Shared package tetris_pkg holds:
  - BOARD_ROWS=23, BOARD_COLS=10, BOARD_BITS=230.
  - The state enum type.
  - The score table constants SCORE_1..SCORE_4.
- Sub-module line_score_lut: combinational, 5-bit k in, 16-bit increment out. Instantiated only under LINE_CLEAR_SCORE_EN.

## Test plan
- Empty board, start -> done at N+24, lines_cleared=0, board_out all zero, score 0.
- Row 22 full, row 21 = 10'b1000000001 -> done at N+26, lines_cleared=1, row 22 = 10'b1000000001, row 21 = 0, score 40 with macro enabled.
- Rows 19..22 full, row 18 has one tile at column 0 -> done at N+32, lines_cleared=4, row 22 = the former row 18, score 1200. Repeating the same input gives score 2400.
- Rows 22 and 20 full, row 21 partial (non-contiguous full rows) -> lines_cleared=2, row 22 = the former row 21, rows 0..21 zero.
- All 230 bits set -> done at N+24+46, lines_cleared=23, board_out=0.
- Reset asserted mid-SCAN -> next edge: busy=0, done=0, board_out=0. A start pulse while busy is ignored: no second done.
